// File: rtl/tdc_event_arbiter.sv
// Timestamps per-channel TDC hits with a free-running coarse counter and
// round-robin merges them into one ready/valid stream, tracking events lost to backpressure.
module tdc_event_arbiter #(
  parameter  int unsigned CHANNEL_COUNT = 2,
  parameter  int unsigned RAW_COUNT     = 9,
  parameter  int unsigned FP_COUNT      = 13,
  parameter  int unsigned COARSE_WIDTH  = 32,
  parameter  int unsigned LOST_WIDTH    = 16,
  localparam int unsigned CHAN_W        = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic                               enable_i,
  input  logic                               tdc_ready_i,
  input  logic                               cc_rst_i,
  input  logic                               clear_lost_i,
  input  logic [CHANNEL_COUNT-1:0]           detect_i,
  input  logic [CHANNEL_COUNT-1:0]           polarity_i,
  input  logic [CHANNEL_COUNT*RAW_COUNT-1:0] raw_i,
  input  logic [CHANNEL_COUNT*FP_COUNT-1:0]  fp_i,
  output logic                               evt_valid_o,
  input  logic                               evt_ready_i,
  output logic [CHAN_W-1:0]                  evt_chan_o,
  output logic                               evt_pol_o,
  output logic [RAW_COUNT-1:0]               evt_raw_o,
  output logic [FP_COUNT-1:0]                evt_fp_o,
  output logic [COARSE_WIDTH-1:0]            evt_coarse_o,
  output logic                               cc_wrap_o,
  output logic [CHANNEL_COUNT-1:0]           lost_o,
  output logic [LOST_WIDTH-1:0]              lost_cnt_o
);

  // Slot/output payload layout: {pol, raw, fp, coarse}
  localparam int unsigned PAY_W = 1 + RAW_COUNT + FP_COUNT + COARSE_WIDTH;
  localparam int unsigned SUM_W = LOST_WIDTH + CHAN_W + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({LOST_WIDTH{1'b1}});

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_e;

  state_e                   state_q, state_d;
  logic [COARSE_WIDTH-1:0]  coarse_q, coarse_d;
  logic                     cc_wrap_q, cc_wrap_d;
  logic [CHAN_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [CHAN_W-1:0]        evt_chan_q, evt_chan_d;
  logic [PAY_W-1:0]         evt_data_q, evt_data_d;
  logic [CHANNEL_COUNT-1:0] slot_full_q, slot_full_d;
  logic [PAY_W-1:0]         slot_data_q [CHANNEL_COUNT];
  logic [PAY_W-1:0]         slot_data_d [CHANNEL_COUNT];
  logic [CHANNEL_COUNT-1:0] lost_q, lost_d;
  logic [LOST_WIDTH-1:0]    lost_cnt_q, lost_cnt_d;

  logic                     load_ok;
  logic                     grant_vld;
  logic [CHAN_W-1:0]        grant_idx;
  logic [CHANNEL_COUNT-1:0] drop;
  logic [SUM_W-1:0]         drop_cnt;
  logic [SUM_W-1:0]         cnt_sum;
  logic                     cap;
  int unsigned              idx;

  // Coarse counter; wrap pulse only on natural rollover, not on clear
  always_comb begin
    coarse_d  = coarse_q + COARSE_WIDTH'(1);
    cc_wrap_d = &coarse_q;
    if (cc_rst_i) begin
      coarse_d  = '0;
      cc_wrap_d = 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    evt_chan_d  = evt_chan_q;
    evt_data_d  = evt_data_q;
    slot_full_d = slot_full_q;
    slot_data_d = slot_data_q;
    lost_d      = lost_q;
    lost_cnt_d  = lost_cnt_q;
    grant_vld   = 1'b0;
    grant_idx   = '0;
    drop        = '0;
    drop_cnt    = '0;
    cnt_sum     = '0;
    cap         = 1'b0;
    idx         = 0;
    load_ok     = (state_q == ST_EMPTY) || evt_ready_i;

    // Round-robin search starting at the stored pointer (last grant + 1)
    if (load_ok) begin
      for (int unsigned i = 0; i < CHANNEL_COUNT; i++) begin
        idx = 32'(rr_ptr_q) + i;
        if (idx >= CHANNEL_COUNT) idx = idx - CHANNEL_COUNT;
        if (!grant_vld && slot_full_q[CHAN_W'(idx)]) begin
          grant_vld = 1'b1;
          grant_idx = CHAN_W'(idx);
        end
      end
    end

    if (grant_vld) begin
      evt_data_d = slot_data_q[grant_idx];
      evt_chan_d = grant_idx;
      rr_ptr_d   = (grant_idx == CHAN_W'(CHANNEL_COUNT - 1)) ? '0 : grant_idx + CHAN_W'(1);
    end

    case (state_q)
      ST_EMPTY: if (grant_vld) state_d = ST_FULL;
      ST_FULL:  if (evt_ready_i && !grant_vld) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase

    // Slot update: a same-cycle drain frees the slot for the new capture
    for (int unsigned c = 0; c < CHANNEL_COUNT; c++) begin
      cap = detect_i[c] && enable_i && tdc_ready_i;
      if (grant_vld && (grant_idx == CHAN_W'(c))) slot_full_d[c] = 1'b0;
      if (cap) begin
        if (slot_full_q[c] && !(grant_vld && (grant_idx == CHAN_W'(c)))) begin
          drop[c] = 1'b1;
        end else begin
          slot_full_d[c] = 1'b1;
          slot_data_d[c] = {polarity_i[c], raw_i[c*RAW_COUNT +: RAW_COUNT],
                            fp_i[c*FP_COUNT +: FP_COUNT], coarse_q};
        end
      end
      drop_cnt = drop_cnt + SUM_W'(drop[c]);
    end

    cnt_sum = SUM_W'(lost_cnt_q) + drop_cnt;
    if (clear_lost_i) begin
      lost_d     = '0;
      lost_cnt_d = '0;
    end else begin
      lost_d     = lost_q | drop;
      lost_cnt_d = (cnt_sum > CNT_MAX) ? {LOST_WIDTH{1'b1}} : LOST_WIDTH'(cnt_sum);
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q     <= ST_EMPTY;
      coarse_q    <= '0;
      cc_wrap_q   <= 1'b0;
      rr_ptr_q    <= '0;
      evt_chan_q  <= '0;
      evt_data_q  <= '0;
      slot_full_q <= '0;
      lost_q      <= '0;
      lost_cnt_q  <= '0;
      for (int unsigned c = 0; c < CHANNEL_COUNT; c++) slot_data_q[c] <= '0;
    end else begin
      state_q     <= state_d;
      coarse_q    <= coarse_d;
      cc_wrap_q   <= cc_wrap_d;
      rr_ptr_q    <= rr_ptr_d;
      evt_chan_q  <= evt_chan_d;
      evt_data_q  <= evt_data_d;
      slot_full_q <= slot_full_d;
      lost_q      <= lost_d;
      lost_cnt_q  <= lost_cnt_d;
      for (int unsigned c = 0; c < CHANNEL_COUNT; c++) slot_data_q[c] <= slot_data_d[c];
    end
  end

  assign evt_valid_o  = (state_q == ST_FULL);
  assign evt_chan_o   = evt_chan_q;
  assign evt_pol_o    = evt_data_q[PAY_W-1];
  assign evt_raw_o    = evt_data_q[COARSE_WIDTH+FP_COUNT +: RAW_COUNT];
  assign evt_fp_o     = evt_data_q[COARSE_WIDTH +: FP_COUNT];
  assign evt_coarse_o = evt_data_q[COARSE_WIDTH-1:0];
  assign cc_wrap_o    = cc_wrap_q;
  assign lost_o       = lost_q;
  assign lost_cnt_o   = lost_cnt_q;

endmodule

// File: tb/tb_tdc_event_arbiter.sv
// Directed bench for tdc_event_arbiter: a default instance plus a narrow-counter
// instance (4-bit coarse, 4-bit lost count) driven by the same stimulus.
module tb_tdc_event_arbiter;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        enable_i, tdc_ready_i, cc_rst_i, clear_lost_i, evt_ready_i;
  logic [1:0]  detect_i, polarity_i;
  logic [17:0] raw_i;
  logic [25:0] fp_i;

  logic        evt_valid, evt_pol, cc_wrap;
  logic [0:0]  evt_chan;
  logic [8:0]  evt_raw;
  logic [12:0] evt_fp;
  logic [31:0] evt_coarse;
  logic [1:0]  lost;
  logic [15:0] lost_cnt;

  logic        s_evt_valid, s_evt_pol, s_cc_wrap;
  logic [0:0]  s_evt_chan;
  logic [8:0]  s_evt_raw;
  logic [12:0] s_evt_fp;
  logic [3:0]  s_evt_coarse;
  logic [1:0]  s_lost;
  logic [3:0]  s_lost_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  tdc_event_arbiter dut (
    .clk_i(clk_i), .reset_i(reset_i), .enable_i(enable_i), .tdc_ready_i(tdc_ready_i),
    .cc_rst_i(cc_rst_i), .clear_lost_i(clear_lost_i), .detect_i(detect_i),
    .polarity_i(polarity_i), .raw_i(raw_i), .fp_i(fp_i), .evt_valid_o(evt_valid),
    .evt_ready_i(evt_ready_i), .evt_chan_o(evt_chan), .evt_pol_o(evt_pol),
    .evt_raw_o(evt_raw), .evt_fp_o(evt_fp), .evt_coarse_o(evt_coarse),
    .cc_wrap_o(cc_wrap), .lost_o(lost), .lost_cnt_o(lost_cnt)
  );

  tdc_event_arbiter #(.COARSE_WIDTH(4), .LOST_WIDTH(4)) dut_s (
    .clk_i(clk_i), .reset_i(reset_i), .enable_i(enable_i), .tdc_ready_i(tdc_ready_i),
    .cc_rst_i(cc_rst_i), .clear_lost_i(clear_lost_i), .detect_i(detect_i),
    .polarity_i(polarity_i), .raw_i(raw_i), .fp_i(fp_i), .evt_valid_o(s_evt_valid),
    .evt_ready_i(evt_ready_i), .evt_chan_o(s_evt_chan), .evt_pol_o(s_evt_pol),
    .evt_raw_o(s_evt_raw), .evt_fp_o(s_evt_fp), .evt_coarse_o(s_evt_coarse),
    .cc_wrap_o(s_cc_wrap), .lost_o(s_lost), .lost_cnt_o(s_lost_cnt)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance to 1ns after the next rising edge
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic pulse_reset();
    reset_i = 1'b0;
    #1;
    reset_i = 1'b1;
  endtask

  initial begin
    reset_i = 1'b0; enable_i = 1'b0; tdc_ready_i = 1'b0; cc_rst_i = 1'b0;
    clear_lost_i = 1'b0; evt_ready_i = 1'b1; detect_i = '0; polarity_i = '0;
    raw_i = '0; fp_i = '0;
    #12;
    check_eq("rst_valid", 64'(evt_valid), 64'd0);
    check_eq("rst_coarse", 64'(evt_coarse), 64'd0);
    check_eq("rst_lost", 64'(lost), 64'd0);
    check_eq("rst_lost_cnt", 64'(lost_cnt), 64'd0);
    check_eq("rst_wrap", 64'(cc_wrap), 64'd0);
    step();
    reset_i = 1'b1; enable_i = 1'b1; tdc_ready_i = 1'b1;

    // T1: single hit on ch0 at coarse 100
    cc_rst_i = 1'b1; step(); cc_rst_i = 1'b0;
    repeat (100) step();
    detect_i = 2'b01; polarity_i = 2'b01; raw_i = {9'h0, 9'h155}; fp_i = {13'h0, 13'h0AB};
    step(); detect_i = '0;
    check_eq("t1_valid_n1", 64'(evt_valid), 64'd0);
    step();
    check_eq("t1_valid_n2", 64'(evt_valid), 64'd1);
    check_eq("t1_chan", 64'(evt_chan), 64'd0);
    check_eq("t1_coarse", 64'(evt_coarse), 64'd100);
    check_eq("t1_coarse_small", 64'(s_evt_coarse), 64'd4);
    check_eq("t1_fp", 64'(evt_fp), 64'h0AB);
    check_eq("t1_raw", 64'(evt_raw), 64'h155);
    check_eq("t1_pol", 64'(evt_pol), 64'd1);
    step();
    check_eq("t1_drained", 64'(evt_valid), 64'd0);

    // T2: both channels in one cycle, fresh pointer
    pulse_reset();
    step(); step();
    detect_i = 2'b11; polarity_i = 2'b10; raw_i = {9'h0A2, 9'h0A1}; fp_i = {13'h122, 13'h011};
    step(); detect_i = '0;
    step();
    check_eq("t2_first_valid", 64'(evt_valid), 64'd1);
    check_eq("t2_first_chan", 64'(evt_chan), 64'd0);
    check_eq("t2_first_fp", 64'(evt_fp), 64'h011);
    check_eq("t2_first_coarse", 64'(evt_coarse), 64'd2);
    step();
    check_eq("t2_second_valid", 64'(evt_valid), 64'd1);
    check_eq("t2_second_chan", 64'(evt_chan), 64'd1);
    check_eq("t2_second_fp", 64'(evt_fp), 64'h122);
    check_eq("t2_second_raw", 64'(evt_raw), 64'h0A2);
    check_eq("t2_second_pol", 64'(evt_pol), 64'd1);
    check_eq("t2_second_coarse", 64'(evt_coarse), 64'd2);
    check_eq("t2_lost", 64'(lost_cnt), 64'd0);
    step();
    check_eq("t2_drained", 64'(evt_valid), 64'd0);

    // T3: backpressure, three hits on ch1
    evt_ready_i = 1'b0; polarity_i = '0; raw_i = '0;
    detect_i = 2'b10;
    fp_i = {13'h001, 13'h0}; step();
    fp_i = {13'h002, 13'h0}; step();
    fp_i = {13'h003, 13'h0}; step();
    detect_i = '0;
    check_eq("t3_valid", 64'(evt_valid), 64'd1);
    check_eq("t3_chan", 64'(evt_chan), 64'd1);
    check_eq("t3_fp_first", 64'(evt_fp), 64'h001);
    check_eq("t3_lost", 64'(lost), 64'b10);
    check_eq("t3_lost_cnt", 64'(lost_cnt), 64'd1);
    check_eq("t3_lost_cnt_small", 64'(s_lost_cnt), 64'd1);
    step(); step();
    check_eq("t3_hold_fp", 64'(evt_fp), 64'h001);
    check_eq("t3_hold_valid", 64'(evt_valid), 64'd1);
    evt_ready_i = 1'b1;
    step();
    check_eq("t3_second_fp", 64'(evt_fp), 64'h002);
    check_eq("t3_second_valid", 64'(evt_valid), 64'd1);
    step();
    check_eq("t3_drained", 64'(evt_valid), 64'd0);

    // Capture blocked while disabled: no event, no loss
    enable_i = 1'b0; detect_i = 2'b11; step(); step(); detect_i = '0; step();
    check_eq("dis_valid", 64'(evt_valid), 64'd0);
    check_eq("dis_lost_cnt", 64'(lost_cnt), 64'd1);
    enable_i = 1'b1;
    clear_lost_i = 1'b1; step(); clear_lost_i = 1'b0;
    check_eq("clr_lost", 64'(lost), 64'd0);
    check_eq("clr_lost_cnt", 64'(lost_cnt), 64'd0);

    // T4: saturating throughput, grants alternate
    pulse_reset();
    detect_i = 2'b11;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k >= 2 && k <= 5) begin
        check_eq($sformatf("t4_valid_%0d", k), 64'(evt_valid), 64'd1);
        check_eq($sformatf("t4_chan_%0d", k), 64'(evt_chan), 64'(k % 2));
      end
      if (k == 10) begin
        check_eq("t4_cnt_mid", 64'(lost_cnt), 64'd9);
        check_eq("t4_cnt_mid_small", 64'(s_lost_cnt), 64'd9);
      end
    end
    check_eq("t4_cnt_end", 64'(lost_cnt), 64'd19);
    check_eq("t4_cnt_sat_small", 64'(s_lost_cnt), 64'd15);
    check_eq("t4_lost_flags", 64'(lost), 64'b11);
    detect_i = '0;
    repeat (4) step();
    check_eq("t4_drained", 64'(evt_valid), 64'd0);

    // T5: 4-bit coarse wrap and clear without wrap pulse
    cc_rst_i = 1'b1; step(); cc_rst_i = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step();
      check_eq($sformatf("t5_wrap_%0d", k), 64'(s_cc_wrap), 64'(k == 16));
    end
    check_eq("t5_wide_no_wrap", 64'(cc_wrap), 64'd0);
    repeat (7) step();
    cc_rst_i = 1'b1; step(); cc_rst_i = 1'b0;
    check_eq("t5_ccrst_no_wrap", 64'(s_cc_wrap), 64'd0);
    step();
    detect_i = 2'b01; step(); detect_i = '0; step();
    check_eq("t5_coarse_small", 64'(s_evt_coarse), 64'd1);
    check_eq("t5_coarse_wide", 64'(evt_coarse), 64'd1);
    step();

    // T6: asynchronous reset mid-stream
    evt_ready_i = 1'b0; detect_i = 2'b11; fp_i = {13'h1FF, 13'h0EE};
    step(); detect_i = '0; step(); step();
    check_eq("t6_pre_valid", 64'(evt_valid), 64'd1);
    check_eq("t6_pre_lost_cnt", 64'(lost_cnt), 64'd19);
    #3;
    reset_i = 1'b0;
    #1;
    check_eq("t6_valid", 64'(evt_valid), 64'd0);
    check_eq("t6_fp", 64'(evt_fp), 64'd0);
    check_eq("t6_lost_cnt", 64'(lost_cnt), 64'd0);
    check_eq("t6_lost", 64'(lost), 64'd0);
    check_eq("t6_small_valid", 64'(s_evt_valid), 64'd0);
    step();
    reset_i = 1'b1; evt_ready_i = 1'b1;
    step(); step();
    check_eq("t6_slots_empty", 64'(evt_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
